apb_rr_arbiter: RTL and testbench

- Shares one APB master port between NUM_REQ requesters, e.g. test sequencers or DMA/CPU agents in the APB subsystem.
- Arbitrates round-robin and runs each granted command as a standard two-phase APB transfer (SETUP then ACCESS).
- Returns read data, an error flag and a one-cycle completion pulse to the requester that was served.
- Adds a programmable pready timeout so a stalled slave cannot hang the bus.

---
 rtl/apb_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_arbiter
// Purpose  : Round-robin arbiter that shares one APB master port between
//            NUM_REQ requesters. It runs each granted command as a two-phase
//            APB transfer and has an optional pready timeout.
// Revision : 1.0  initial release
// ============================================================================
module apb_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*AW-1:0]       req_addr,
   input  logic [NUM_REQ*DW-1:0]       req_wdata,
   output logic [NUM_REQ-1:0]          ack,
   output logic [DW-1:0]               rsp_rdata,
   output logic                        rsp_err,
   output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
   output logic                        busy,
   output logic [AW-1:0]               paddr,
   output logic [DW-1:0]               pwdata,
   output logic                        pwrite,
   output logic                        psel,
   output logic                        penable,
   input  logic                        pready,
   input  logic [DW-1:0]               prdata
);

   localparam int IDW = $clog2(NUM_REQ);
   // The counter must be able to hold TIMEOUT-1; keep it at least 1 bit wide
   // so the design still elaborates when the timeout is disabled.
   localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t               state_q,     state_d;
   logic [IDW-1:0]       ptr_q,       ptr_d;
   logic [IDW-1:0]       gnt_id_q,    gnt_id_d;
   logic [AW-1:0]        paddr_q,     paddr_d;
   logic [DW-1:0]        pwdata_q,    pwdata_d;
   logic                 pwrite_q,    pwrite_d;
   logic                 psel_q,      psel_d;
   logic                 penable_q,   penable_d;
   logic                 busy_q,      busy_d;
   logic [NUM_REQ-1:0]   ack_q,       ack_d;
   logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q,   rsp_err_d;
   logic [CW-1:0]        cnt_q,       cnt_d;

   logic [IDW-1:0]       win;
   logic [IDW-1:0]       cand;
   logic                 found;

   // Pick the first pending requester after the last grant, wrapping around.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state and next-output logic for the APB transfer sequencer.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_id_d    = gnt_id_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      busy_d      = busy_q;
      ack_d       = ack_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               paddr_d   = req_addr[int'(win)*AW +: AW];
               pwdata_d  = req_wdata[int'(win)*DW +: DW];
               pwrite_d  = req_write[win];
               gnt_id_d  = win;
               ptr_d     = win;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            // pready wins over a timeout landing on the same edge.
            if (pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (!pwrite_q) begin
                  rsp_rdata_d = prdata;
               end
               rsp_err_d = 1'b0;
               ack_d     = NUM_REQ'(1) << gnt_id_q;
               state_d   = S_RESP;
            end else if (TIMEOUT > 0) begin
               if (cnt_q == TO_LAST) begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  rsp_err_d = 1'b1;
                  ack_d     = NUM_REQ'(1) << gnt_id_q;
                  state_d   = S_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RESP: begin
            ack_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; the pointer resets to the last index so
   // requester 0 is first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= IDW'(NUM_REQ - 1);
         gnt_id_q    <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         busy_q      <= 1'b0;
         ack_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_id_q    <= gnt_id_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ack       = ack_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pwrite    = pwrite_q;
   assign psel      = psel_q;
   assign penable   = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_rr_arbiter
// Purpose  : Directed self-checking bench for apb_rr_arbiter (4 requesters,
//            32-bit address/data, TIMEOUT = 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_rr_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [3:0]    req_write;
   logic [127:0]  req_addr;
   logic [127:0]  req_wdata;
   logic [3:0]    ack;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [1:0]    gnt_id;
   logic          busy;
   logic [31:0]   paddr;
   logic [31:0]   pwdata;
   logic          pwrite;
   logic          psel;
   logic          penable;
   logic          pready;
   logic [31:0]   prdata;

   int vectors     = 0;
   int miscompares = 0;

   apb_rr_arbiter #(
      .NUM_REQ (4),
      .AW      (32),
      .DW      (32),
      .TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pready    (pready),
      .prdata    (prdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample and drive 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_write[i]         = w;
      req_addr[i*32 +: 32]  = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      pready    = 1'b0;
      prdata    = '0;
      repeat (2) @(posedge clk);
      #1;

      // ---- reset state ----
      check("rst_ack",     ack,       4'b0000);
      check("rst_psel",    psel,      1'b0);
      check("rst_penable", penable,   1'b0);
      check("rst_busy",    busy,      1'b0);
      check("rst_gnt",     gnt_id,    2'd0);
      check("rst_rdata",   rsp_rdata, 32'h0);
      check("rst_err",     rsp_err,   1'b0);
      check("rst_paddr",   paddr,     32'h0);
      rst = 1'b0;
      tick();

      // ---- single write, requester 0, pready tied high ----
      pready = 1'b1;
      set_cmd(0, 1'b1, 32'h4, 32'h12345678);
      req[0] = 1'b1;
      tick();                                   // grant -> SETUP
      check("wr_setup_psel",    psel,    1'b1);
      check("wr_setup_penable", penable, 1'b0);
      check("wr_pwrite",        pwrite,  1'b1);
      check("wr_paddr",         paddr,   32'h4);
      check("wr_pwdata",        pwdata,  32'h12345678);
      check("wr_busy",          busy,    1'b1);
      check("wr_gnt",           gnt_id,  2'd0);
      tick();                                   // ACCESS
      check("wr_access_psel",    psel,    1'b1);
      check("wr_access_penable", penable, 1'b1);
      check("wr_access_ack",     ack,     4'b0000);
      tick();                                   // RESP
      check("wr_ack",     ack,     4'b0001);
      check("wr_err",     rsp_err, 1'b0);
      check("wr_psel_lo", psel,    1'b0);
      check("wr_pen_lo",  penable, 1'b0);
      req[0] = 1'b0;
      tick();                                   // IDLE
      check("wr_ack_pulse", ack,       4'b0000);
      check("wr_busy_lo",   busy,      1'b0);
      check("wr_rdata",     rsp_rdata, 32'h0);

      // ---- read with three wait states, requester 2 ----
      pready = 1'b0;
      set_cmd(2, 1'b0, 32'h8, 32'h0);
      req[2] = 1'b1;
      tick();
      check("rd_gnt",    gnt_id, 2'd2);
      check("rd_pwrite", pwrite, 1'b0);
      check("rd_paddr",  paddr,  32'h8);
      tick();
      check("rd_pen_1", penable, 1'b1);
      tick();
      check("rd_pen_2", penable, 1'b1);
      tick();
      check("rd_pen_3", penable, 1'b1);
      tick();
      check("rd_pen_4", penable, 1'b1);
      check("rd_wait_ack", ack, 4'b0000);
      pready = 1'b1;
      prdata = 32'hCAFEF00D;
      tick();
      check("rd_ack",   ack,       4'b0100);
      check("rd_rdata", rsp_rdata, 32'hCAFEF00D);
      check("rd_gnt2",  gnt_id,    2'd2);
      check("rd_err",   rsp_err,   1'b0);
      req[2] = 1'b0;
      prdata = 32'h0;
      tick();

      // ---- timeout on requester 3 (write, slave never ready) ----
      pready = 1'b0;
      set_cmd(3, 1'b1, 32'hC, 32'h55AA55AA);
      req[3] = 1'b1;
      tick();
      check("to_gnt", gnt_id, 2'd3);
      tick();                                   // first ACCESS cycle
      for (int k = 0; k < 15; k++) begin
         tick();
         check("to_pen_hold", penable, 1'b1);
      end
      check("to_no_ack", ack, 4'b0000);
      tick();                                   // 16th ACCESS edge
      check("to_ack",   ack,       4'b1000);
      check("to_err",   rsp_err,   1'b1);
      check("to_psel",  psel,      1'b0);
      check("to_pen",   penable,   1'b0);
      check("to_rdata", rsp_rdata, 32'hCAFEF00D);
      req[3] = 1'b0;
      tick();

      // ---- round robin: pointer at 3, all four pending -> 0,1,2,3 ----
      pready = 1'b1;
      for (int n = 0; n < 4; n++) set_cmd(n, 1'b1, 32'h100 + 32'(n) * 32'h10, 32'hA0 + 32'(n));
      req = 4'b1111;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("rr_gnt",   gnt_id, 64'(n));
         check("rr_paddr", paddr,  64'h100 + 64'(n) * 64'h10);
         tick();
         tick();
         check("rr_ack", ack, 64'(4'b0001 << n));
         check("rr_err", rsp_err, 1'b0);
         req[n] = 1'b0;
         tick();
      end

      // ---- a lone requester held high is served back-to-back ----
      req[0] = 1'b1;
      tick();
      check("solo_gnt_a", gnt_id, 2'd0);
      tick();
      tick();
      check("solo_ack_a", ack, 4'b0001);
      tick();                                   // IDLE, req still high
      tick();
      check("solo_gnt_b",  gnt_id, 2'd0);
      check("solo_psel_b", psel,   1'b1);
      tick();
      tick();
      check("solo_ack_b", ack, 4'b0001);
      req[0] = 1'b0;
      tick();

      // ---- asynchronous reset during ACCESS ----
      pready = 1'b0;
      set_cmd(1, 1'b0, 32'h14, 32'h0);
      set_cmd(3, 1'b0, 32'h1C, 32'h0);
      req[3] = 1'b1;
      tick();
      tick();
      check("mr_pen_before", penable, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_psel_now", psel,    1'b0);
      check("mr_pen_now",  penable, 1'b0);
      check("mr_busy_now", busy,    1'b0);
      tick();
      check("mr_no_ack", ack, 4'b0000);
      rst    = 1'b0;
      req[1] = 1'b1;
      pready = 1'b1;
      tick();
      check("mr_gnt1",  gnt_id, 2'd1);
      check("mr_paddr", paddr,  32'h14);
      tick();
      tick();
      check("mr_ack1", ack, 4'b0010);
      req[1] = 1'b0;
      tick();
      tick();
      check("mr_gnt3", gnt_id, 2'd3);
      tick();
      tick();
      check("mr_ack3", ack, 4'b1000);
      req[3] = 1'b0;
      tick();
      check("end_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
